pci_bus_arbiter: RTL and testbench

//  Central PCI bus arbiter: shares one FRAME/AD/CBE/IRDY bus between N initiators via REQ#/GNT#.

---
 rtl/pci_pkg.sv | 15 +
 rtl/pci_bus_arbiter_if.sv | 26 ++
 rtl/pci_rr_picker.sv | 38 +++
 rtl/pci_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI bus arbiter: FSM state encoding and
// the active-low signalling levels used on REQ#/GNT#/FRAME#/IRDY#.
package pci_pkg;

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_TURN  = 2'd1,
        ST_GRANT = 2'd2,
        ST_BUSY  = 2'd3
    } arb_state_e;

    localparam logic ACT_LO   = 1'b0;
    localparam logic INACT_HI = 1'b1;

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Arbiter-side view of the shared PCI bus: REQ#/GNT# pairs, FRAME#/IRDY# snoop
// and arbiter status. 'master' is the arbiter, 'slave' is the initiator side.
interface pci_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int OW = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] gnt;
    logic                 frame;
    logic                 irdy;
    logic [OW-1:0]        owner;
    logic                 busy;
    logic                 timeout;

    modport master (
        input  req, frame, irdy,
        output gnt, owner, busy, timeout
    );

    modport slave (
        output req, frame, irdy,
        input  gnt, owner, busy, timeout
    );

endinterface

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first active-low request searching from
// owner+1 upward with wrap; owner itself is tried last unless excluded.
module pci_rr_picker
    import pci_pkg::*;
#(
    parameter int N_MASTERS = 4,
    localparam int OW = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [OW-1:0]        owner,
    input  logic                 exclude_owner,
    output logic [OW-1:0]        winner,
    output logic                 any_valid
);

    logic [OW-1:0] idx_s;
    logic          take_s;
    logic [OW-1:0] winner_s;
    logic          any_s;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        idx_s    = {OW{1'b0}};
        take_s   = 1'b0;
        winner_s = {OW{1'b0}};
        any_s    = 1'b0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx_s    = OW'((int'(owner) + i) % N_MASTERS);
            take_s   = (req[idx_s] == ACT_LO) && !(exclude_owner && (i == N_MASTERS));
            winner_s = take_s ? idx_s : winner_s;
            any_s    = any_s | take_s;
        end
    end

    assign winner    = winner_s;
    assign any_valid = any_s;

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ#/GNT# with bus parking, one-clock
// turnaround between different owners and revocation of unused grants.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = 16,
    parameter int PARK_MASTER = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    pci_bus_arbiter_if.master bus
);

    localparam int OW = $clog2(N_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [OW-1:0]        PARK_IDX = OW'(PARK_MASTER);
    localparam logic [CW-1:0]        TO_LAST  = CW'(GNT_TIMEOUT - 1);
    localparam logic [CW-1:0]        CNT_MAX  = {CW{1'b1}};
    localparam logic [N_MASTERS-1:0] GNT_NONE = {N_MASTERS{INACT_HI}};

    function automatic logic [N_MASTERS-1:0] gnt_for(input logic [OW-1:0] idx);
        logic [N_MASTERS-1:0] m;
        m      = GNT_NONE;
        m[idx] = ACT_LO;
        return m;
    endfunction

    arb_state_e           state_r;
    logic [N_MASTERS-1:0] gnt_r;
    logic [OW-1:0]        owner_r;
    logic [OW-1:0]        winner_r;
    logic                 busy_r;
    logic                 timeout_r;
    logic [CW-1:0]        cnt_r;

    logic                 bus_idle_s;
    logic                 exclude_s;
    logic [OW-1:0]        winner_s;
    logic                 any_s;
    arb_state_e           rearb_state_s;
    logic [N_MASTERS-1:0] rearb_gnt_s;
    logic [OW-1:0]        rearb_owner_s;

    assign bus_idle_s = (bus.frame == INACT_HI) && (bus.irdy == INACT_HI);
    // Only the parked state may pick the current owner again through the picker.
    assign exclude_s  = (state_r != ST_PARK);

    pci_rr_picker #(
        .N_MASTERS (N_MASTERS)
    ) u_picker (
        .req           (bus.req),
        .owner         (owner_r),
        .exclude_owner (exclude_s),
        .winner        (winner_s),
        .any_valid     (any_s)
    );

    // Outcome of giving up the current grant: turnaround to another master, or park.
    always_comb begin
        rearb_state_s = ST_PARK;
        rearb_gnt_s   = gnt_for(PARK_IDX);
        rearb_owner_s = PARK_IDX;
        if (any_s) begin
            rearb_state_s = ST_TURN;
            rearb_gnt_s   = GNT_NONE;
            rearb_owner_s = owner_r;
        end else begin
            rearb_state_s = ST_PARK;
            rearb_gnt_s   = gnt_for(PARK_IDX);
            rearb_owner_s = PARK_IDX;
        end
    end

    // Arbiter FSM with registered GNT/OWNER/BUSY/TIMEOUT and the idle-grant counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_PARK;
            gnt_r     <= GNT_NONE;
            owner_r   <= PARK_IDX;
            winner_r  <= PARK_IDX;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_PARK: begin
                    gnt_r   <= gnt_for(PARK_IDX);
                    owner_r <= PARK_IDX;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    if (bus_idle_s && any_s) begin
                        if (winner_s == PARK_IDX) begin
                            state_r <= ST_GRANT;
                        end else begin
                            winner_r <= winner_s;
                            gnt_r    <= GNT_NONE;
                            state_r  <= ST_TURN;
                        end
                    end else begin
                        state_r <= ST_PARK;
                    end
                end
                ST_TURN: begin
                    gnt_r   <= gnt_for(winner_r);
                    owner_r <= winner_r;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_GRANT;
                end
                ST_GRANT: begin
                    // A started transaction beats a timeout expiring on the same edge.
                    if (bus.frame == ACT_LO) begin
                        busy_r  <= 1'b1;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_BUSY;
                    end else if (!bus_idle_s) begin
                        state_r <= ST_GRANT;
                    end else if (bus.req[owner_r] == INACT_HI) begin
                        winner_r <= winner_s;
                        gnt_r    <= rearb_gnt_s;
                        owner_r  <= rearb_owner_s;
                        state_r  <= rearb_state_s;
                    end else if (cnt_r == TO_LAST) begin
                        timeout_r <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                        winner_r  <= winner_s;
                        gnt_r     <= rearb_gnt_s;
                        owner_r   <= rearb_owner_s;
                        state_r   <= rearb_state_s;
                    end else begin
                        cnt_r   <= (cnt_r != CNT_MAX) ? cnt_r + CW'(1) : cnt_r;
                        state_r <= ST_GRANT;
                    end
                end
                ST_BUSY: begin
                    if (!bus_idle_s) begin
                        state_r <= ST_BUSY;
                    end else if (!any_s && (bus.req[owner_r] == ACT_LO)) begin
                        busy_r  <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_GRANT;
                    end else begin
                        busy_r   <= 1'b0;
                        winner_r <= winner_s;
                        gnt_r    <= rearb_gnt_s;
                        owner_r  <= rearb_owner_s;
                        state_r  <= rearb_state_s;
                    end
                end
                default: begin
                    state_r <= ST_PARK;
                    gnt_r   <= GNT_NONE;
                    owner_r <= PARK_IDX;
                    busy_r  <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.owner   = owner_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (4 masters, timeout 16, park on 0):
// a vector table for single-clock behaviour plus sequences for multi-cycle cases.
module tb_pci_bus_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pci_bus_arbiter_if #(.N_MASTERS(4)) bus();

    pci_bus_arbiter #(
        .N_MASTERS   (4),
        .GNT_TIMEOUT (16),
        .PARK_MASTER (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       frame;
        logic       irdy;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t vecs[14];
    int   order[5];

    function automatic logic [3:0] gmask(input int m);
        logic [3:0] g;
        g    = 4'b1111;
        g[m] = 1'b0;
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // At most one grant may be active in any clock.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(~bus.gnt) > 1) begin
                failures++;
                $display("FAIL gnt_onehot actual=%b expected=at_most_one_low at %0t", bus.gnt, $time);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n     = 1'b0;
        bus.req   = 4'b1111;
        bus.frame = 1'b1;
        bus.irdy  = 1'b1;

        //               rst   req      fr    ir    gnt      own    busy  to
        vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0}; // park after reset
        vecs[1]  = '{1'b1, 4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0}; // park master, no turn
        vecs[2]  = '{1'b1, 4'b1110, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0}; // frame -> busy
        vecs[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0}; // idle -> park
        vecs[4]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0}; // turn clock
        vecs[5]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b0}; // grant 2
        vecs[6]  = '{1'b1, 4'b1011, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0}; // busy
        vecs[7]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0}; // irdy still low
        vecs[9]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0}; // park
        vecs[10] = '{1'b1, 4'b1011, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0}; // bus busy, hold park
        vecs[11] = '{1'b1, 4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0}; // turn
        vecs[12] = '{1'b1, 4'b1101, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b0}; // latched winner kept
        vecs[13] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0}; // released -> park

        order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 0; order[4] = 1;

        // Reset state
        step();
        step();
        check("rst_gnt",   32'(bus.gnt),   32'(4'b1111));
        check("rst_owner", 32'(bus.owner), 32'(2'd0));
        check("rst_busy",  32'(bus.busy),  32'(1'b0));
        check("rst_to",    32'(bus.timeout), 32'(1'b0));

        for (int v = 0; v < 14; v++) begin
            rst_n     = vecs[v].rst_n;
            bus.req   = vecs[v].req;
            bus.frame = vecs[v].frame;
            bus.irdy  = vecs[v].irdy;
            step();
            check($sformatf("vec%0d", v),
                  {24'd0, bus.gnt, bus.owner, bus.busy, bus.timeout},
                  {24'd0, vecs[v].gnt, vecs[v].owner, vecs[v].busy, vecs[v].timeout});
        end

        // Round-robin rotation with all masters requesting
        bus.req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr_turn%0d", k), 32'(bus.gnt), 32'(4'b1111));
            step();
            check($sformatf("rr_gnt%0d", k),   32'(bus.gnt),   32'(gmask(order[k])));
            check($sformatf("rr_owner%0d", k), 32'(bus.owner), 32'(order[k]));
            bus.frame = 1'b0;
            step();
            check($sformatf("rr_busy%0d", k), 32'(bus.busy), 32'(1'b1));
            step();
            bus.frame = 1'b1;
        end
        bus.req = 4'b1111;
        step();
        check("rr_park", 32'(bus.gnt), 32'(4'b1110));

        // Unused grant revoked after 16 idle clocks, next requester served
        bus.req = 4'b1101;
        step();
        step();
        check("to_gnt1", 32'(bus.gnt), 32'(4'b1101));
        bus.req = 4'b0101;
        for (int c = 0; c < 15; c++) begin
            step();
            check($sformatf("to_wait%0d", c), {30'd0, bus.timeout, &bus.gnt}, {30'd0, 1'b0, 1'b0});
        end
        step();
        check("to_pulse", 32'(bus.timeout), 32'(1'b1));
        check("to_gnt_off", 32'(bus.gnt), 32'(4'b1111));
        step();
        check("to_pulse_end", 32'(bus.timeout), 32'(1'b0));
        check("to_next_gnt", 32'(bus.gnt), 32'(4'b0111));
        check("to_next_owner", 32'(bus.owner), 32'(2'd3));
        bus.req = 4'b1111;
        step();
        check("to_park", 32'(bus.gnt), 32'(4'b1110));

        // FRAME arriving on the expiry clock wins over the timeout
        bus.req = 4'b1101;
        step();
        step();
        for (int c = 0; c < 15; c++) begin
            step();
        end
        check("sim_pre_to", 32'(bus.timeout), 32'(1'b0));
        bus.frame = 1'b0;
        step();
        check("sim_busy", 32'(bus.busy), 32'(1'b1));
        check("sim_no_to", 32'(bus.timeout), 32'(1'b0));
        check("sim_gnt", 32'(bus.gnt), 32'(4'b1101));
        bus.frame = 1'b1;
        bus.req   = 4'b1111;
        step();
        check("sim_park", 32'(bus.gnt), 32'(4'b1110));

        // Asynchronous reset in the middle of a transaction
        bus.req = 4'b1011;
        step();
        step();
        bus.frame = 1'b0;
        step();
        check("ar_busy", 32'(bus.busy), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt",   32'(bus.gnt),   32'(4'b1111));
        check("ar_busy0", 32'(bus.busy),  32'(1'b0));
        check("ar_owner", 32'(bus.owner), 32'(2'd0));
        bus.frame = 1'b1;
        bus.req   = 4'b1111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("ar_park", 32'(bus.gnt), 32'(4'b1110));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
